zxuno_regport: RTL and testbench
================================

ZXUNO_REGPORT -- requirements
Module: zxuno_regport

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_PORT, 16'hFC3B, Z80 I/O port that selects the register address.
- DATA_PORT, 16'hFD3B, Z80 I/O port that accesses the selected register.

REQ-002 The block SHALL have these ports, in order:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- a  in  16  Z80 address bus, synchronous to clk.
- iorq_n  in  1  Z80 I/O request, active-low.
- rd_n  in  1  Z80 read strobe, active-low.
- wr_n  in  1  Z80 write strobe, active-low.
- din  in  8  Z80 data bus, write data.
- zxuno_addr  out  8  currently selected register address (registered).
- zxuno_regrd  out  1  level: a DATA_PORT read is in progress.
- zxuno_regwr  out  1  single-cycle pulse: a DATA_PORT write has started.
- regaddr_changed  out  1  single-cycle pulse: an ADDR_PORT write has completed.
- dout  out  8  readback value of zxuno_addr for ADDR_PORT reads.
- oe_n  out  1  active-low drive enable for dout.

Function
REQ-003 Port match SHALL be a full 16-bit compare of a against ADDR_PORT or DATA_PORT; no partial decoding.

REQ-004 Access qualifiers (combinational) SHALL be:
- wr_acc = !iorq_n & !wr_n
- rd_acc = !iorq_n & !rd_n

REQ-005 The FSM SHALL have states IDLE, AWR, DWR, RDX.
- IDLE -> AWR on wr_acc with ADDR_PORT match.
- IDLE -> DWR on wr_acc with DATA_PORT match.
- IDLE -> RDX on rd_acc with either port matched.
- Any other state -> IDLE in the first cycle the respective access qualifier is deasserted.

REQ-006 On the IDLE->AWR transition cycle, zxuno_addr SHALL load din, visible the next cycle; no further loads occur while in AWR.

REQ-007 regaddr_changed SHALL be high for exactly one cycle: the cycle after zxuno_addr updates. It SHALL pulse even when the written value equals the old value.

REQ-008 zxuno_regwr SHALL be high for exactly one cycle on entry to DWR (registered, one cycle after the IDLE->DWR decision); it SHALL NOT repeat while the strobe is held.

REQ-009 zxuno_regrd SHALL be combinational: rd_acc & (a==DATA_PORT). It stays high for the whole strobe and drops in the same cycle the strobe drops, independent of the FSM.

REQ-010 oe_n SHALL be combinational: !(rd_acc & (a==ADDR_PORT)). dout SHALL equal zxuno_addr, registered every cycle.

REQ-011 Simultaneous rd_n and wr_n low SHALL be treated as a write; zxuno_regrd and oe_n SHALL be suppressed (inactive) while wr_acc is high.

REQ-012 Address change mid-strobe SHALL NOT retrigger a transition; the FSM waits for the strobe to release and return to IDLE.

REQ-013 Back-to-back accesses SHALL be accepted with a minimum of one strobe-inactive cycle between them.

Reset
REQ-014 While rst is high, at the clock edge:
- zxuno_addr=8'h00, dout=8'h00, FSM=IDLE
- zxuno_regwr=0, regaddr_changed=0

REQ-015 Reset SHALL override any access in progress. A strobe still held low after rst deasserts SHALL be treated as a new access in the first cycle after reset.

Verification
REQ-016 Write 8'hFF to 16'hFC3B, strobe held 4 cycles -> zxuno_addr=8'hFF one cycle after the first strobe cycle; regaddr_changed high for exactly 1 cycle, the next cycle.

REQ-017 Write 8'h05 to 16'hFC3B twice, with 2 idle cycles between -> two separate single-cycle regaddr_changed pulses; zxuno_addr=8'h05 throughout.

REQ-018 Read 16'hFD3B for 3 cycles -> zxuno_regrd high exactly 3 cycles; oe_n=1; no regwr or regaddr_changed pulses.

REQ-019 Write to 16'hFD3B with strobe held 5 cycles -> exactly one zxuno_regwr pulse; zxuno_addr unchanged.

REQ-020 After zxuno_addr=8'h3C, read 16'hFC3B -> oe_n=0 during the strobe, dout=8'h3C; access to 16'hFC3A -> no response of any kind.

REQ-021 Assert rst mid-way through an ADDR_PORT write -> zxuno_addr=8'h00 and no regaddr_changed pulse during reset; a strobe still low after reset -> reloads zxuno_addr from din, then one regaddr_changed pulse.

Source files
------------

// File: rtl/zxuno_regport.sv
// ZX-Uno register port: a Z80 I/O port pair that selects an 8-bit register
// address (ADDR_PORT) and signals accesses to the selected register (DATA_PORT).
module zxuno_regport #(
    parameter logic [15:0] ADDR_PORT = 16'hFC3B,
    parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic        regaddr_changed,
    output logic [7:0]  dout,
    output logic        oe_n
);

    typedef enum logic [1:0] {StIdle, StAwr, StDwr, StRdx} state_e;

    state_e     state_q, state_d;
    logic       wr_acc, rd_acc;
    logic       hit_addr, hit_data;
    logic       load_addr, start_dwr;
    logic [7:0] addr_q;
    logic [7:0] dout_q;
    logic       load_q;
    logic       changed_q;
    logic       regwr_q;

    // Access qualifiers and full 16-bit port decode.
    always_comb begin
        wr_acc   = !iorq_n && !wr_n;
        rd_acc   = !iorq_n && !rd_n;
        hit_addr = (a == ADDR_PORT);
        hit_data = (a == DATA_PORT);
    end

    // Next-state decode; a write wins over a simultaneous read, and only IDLE can
    // start an access, so address changes mid-strobe are ignored.
    always_comb begin
        state_d   = state_q;
        load_addr = 1'b0;
        start_dwr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_acc) begin
                    if (hit_addr) begin
                        state_d   = StAwr;
                        load_addr = 1'b1;
                    end else if (hit_data) begin
                        state_d   = StDwr;
                        start_dwr = 1'b1;
                    end
                end else if (rd_acc && (hit_addr || hit_data)) begin
                    state_d = StRdx;
                end
            end
            StAwr, StDwr: begin
                if (!wr_acc) state_d = StIdle;
            end
            StRdx: begin
                if (!rd_acc) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, address register and pulse pipeline; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= 8'h00;
            dout_q    <= 8'h00;
            load_q    <= 1'b0;
            changed_q <= 1'b0;
            regwr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= addr_q;
            load_q    <= load_addr;
            // Pulse lands the cycle after the new address becomes visible.
            changed_q <= load_q;
            regwr_q   <= start_dwr;
            if (load_addr) addr_q <= din;
        end
    end

    // Read-side strobes are purely combinational and masked during a write.
    always_comb begin
        zxuno_regrd     = rd_acc && !wr_acc && hit_data;
        oe_n            = !(rd_acc && !wr_acc && hit_addr);
        zxuno_addr      = addr_q;
        zxuno_regwr     = regwr_q;
        regaddr_changed = changed_q;
        dout            = dout_q;
    end

endmodule

// File: tb/tb_zxuno_regport.sv
// Self-checking bench for zxuno_regport: directed scenarios followed by random
// cycle-level bus traffic, compared against a transaction-level reference model.
module tb_zxuno_regport;

    localparam logic [15:0] AP = 16'hFC3B;
    localparam logic [15:0] DP = 16'hFD3B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h0000;
    logic        iorq_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic        regaddr_changed;
    logic [7:0]  dout;
    logic        oe_n;

    always #5 clk = ~clk;

    zxuno_regport #(
        .ADDR_PORT(AP),
        .DATA_PORT(DP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .iorq_n         (iorq_n),
        .rd_n           (rd_n),
        .wr_n           (wr_n),
        .din            (din),
        .zxuno_addr     (zxuno_addr),
        .zxuno_regrd    (zxuno_regrd),
        .zxuno_regwr    (zxuno_regwr),
        .regaddr_changed(regaddr_changed),
        .dout           (dout),
        .oe_n           (oe_n)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: register contents, open transaction kind, and the cycle
    // numbers at which each single-cycle pulse is due.
    bit         m_valid = 0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_dout = 8'h00;
    int         open_kind = 0;  // 0 none, 1 write, 2 read
    int         chg_due_q[$];
    int         regwr_due_q[$];

    // Observed activity tallies for the directed scenarios.
    int cnt_chg, cnt_regwr, cnt_regrd, cnt_oe;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic chg_due(input int c);
        chg_due = 1'b0;
        foreach (chg_due_q[i]) if (chg_due_q[i] == c) chg_due = 1'b1;
    endfunction

    function automatic logic regwr_due(input int c);
        regwr_due = 1'b0;
        foreach (regwr_due_q[i]) if (regwr_due_q[i] == c) regwr_due = 1'b1;
    endfunction

    task automatic clear_counts();
        cnt_chg = 0; cnt_regwr = 0; cnt_regrd = 0; cnt_oe = 0;
    endtask

    // One bus cycle: drive inputs at the falling edge, check, then advance model.
    task automatic step(input logic r, input logic [15:0] aa, input logic io,
                        input logic rn, input logic wn, input logic [7:0] d);
        logic wr, rd;
        @(negedge clk);
        rst = r; a = aa; iorq_n = io; rd_n = rn; wr_n = wn; din = d;
        #1;
        wr = !io && !wn;
        rd = !io && !rn;
        check("regrd", {7'b0, zxuno_regrd}, {7'b0, rd && !wr && (aa == DP)});
        check("oe_n", {7'b0, oe_n}, {7'b0, !(rd && !wr && (aa == AP))});
        if (m_valid) begin
            check("zxuno_addr", zxuno_addr, m_addr);
            check("dout", dout, m_dout);
            check("regwr", {7'b0, zxuno_regwr}, {7'b0, regwr_due(cyc)});
            check("regaddr_changed", {7'b0, regaddr_changed}, {7'b0, chg_due(cyc)});
        end
        if (regaddr_changed === 1'b1) cnt_chg++;
        if (zxuno_regwr === 1'b1) cnt_regwr++;
        if (zxuno_regrd === 1'b1) cnt_regrd++;
        if (oe_n === 1'b0) cnt_oe++;
        if (r) begin
            m_addr = 8'h00; m_dout = 8'h00; open_kind = 0; m_valid = 1;
            chg_due_q.delete(); regwr_due_q.delete();
        end else begin
            m_dout = m_addr;
            case (open_kind)
                1: if (!wr) open_kind = 0;
                2: if (!rd) open_kind = 0;
                default: begin
                    if (wr) begin
                        if (aa == AP) begin
                            m_addr = d;
                            chg_due_q.push_back(cyc + 2);
                            open_kind = 1;
                        end else if (aa == DP) begin
                            regwr_due_q.push_back(cyc + 1);
                            open_kind = 1;
                        end
                    end else if (rd && (aa == AP || aa == DP)) begin
                        open_kind = 2;
                    end
                end
            endcase
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic do_wr(input logic [15:0] aa, input logic [7:0] d, input int hold);
        for (int i = 0; i < hold; i++) step(1'b0, aa, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic do_rd(input logic [15:0] aa, input int hold);
        for (int i = 0; i < hold; i++) step(1'b0, aa, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    logic [15:0] ad;
    int          kind, hold, gap;
    logic        io, rr;

    initial begin
        // Reset
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00);
        idle(2);
        check("reset_addr", zxuno_addr, 8'h00);
        check("reset_dout", dout, 8'h00);

        // Address write held 4 cycles: one load, one changed pulse.
        clear_counts();
        do_wr(AP, 8'hFF, 4);
        idle(3);
        check("wr_ff_addr", zxuno_addr, 8'hFF);
        check("wr_ff_chg_count", 8'(cnt_chg), 8'd1);

        // Same value written twice: two separate pulses.
        clear_counts();
        do_wr(AP, 8'h05, 1);
        idle(2);
        do_wr(AP, 8'h05, 1);
        idle(3);
        check("wr05_twice_chg_count", 8'(cnt_chg), 8'd2);
        check("wr05_twice_addr", zxuno_addr, 8'h05);

        // Data port read for 3 cycles.
        clear_counts();
        do_rd(DP, 3);
        idle(2);
        check("rd_data_regrd_count", 8'(cnt_regrd), 8'd3);
        check("rd_data_oe_count", 8'(cnt_oe), 8'd0);
        check("rd_data_side_pulses", 8'(cnt_regwr + cnt_chg), 8'd0);

        // Data port write held 5 cycles: one regwr pulse, address untouched.
        clear_counts();
        do_wr(DP, 8'hAA, 5);
        idle(2);
        check("wr_data_regwr_count", 8'(cnt_regwr), 8'd1);
        check("wr_data_addr", zxuno_addr, 8'h05);

        // Address readback, then a near-miss port that must be ignored.
        do_wr(AP, 8'h3C, 1);
        idle(2);
        clear_counts();
        do_rd(AP, 2);
        check("rd_addr_dout", dout, 8'h3C);
        idle(1);
        check("rd_addr_oe_count", 8'(cnt_oe), 8'd2);
        clear_counts();
        do_wr(16'hFC3A, 8'h77, 2);
        idle(1);
        do_rd(16'hFC3A, 2);
        idle(3);
        check("miss_activity", 8'(cnt_chg + cnt_regwr + cnt_regrd + cnt_oe), 8'd0);
        check("miss_addr", zxuno_addr, 8'h3C);

        // Simultaneous rd/wr on the address port behaves as a write.
        clear_counts();
        step(1'b0, AP, 1'b0, 1'b0, 1'b0, 8'h5A);
        step(1'b0, AP, 1'b0, 1'b0, 1'b0, 8'h5A);
        idle(3);
        check("rdwr_oe_count", 8'(cnt_oe), 8'd0);
        check("rdwr_addr", zxuno_addr, 8'h5A);

        // Reset in the middle of an address write, strobe still low afterwards.
        clear_counts();
        step(1'b0, AP, 1'b0, 1'b1, 1'b0, 8'h81);
        step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h81);
        step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h81);
        check("rst_mid_addr", zxuno_addr, 8'h00);
        check("rst_mid_chg_count", 8'(cnt_chg), 8'd0);
        step(1'b0, AP, 1'b0, 1'b1, 1'b0, 8'h81);
        step(1'b0, AP, 1'b0, 1'b1, 1'b0, 8'h81);
        idle(3);
        check("rst_reload_addr", zxuno_addr, 8'h81);
        check("rst_reload_chg_count", 8'(cnt_chg), 8'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ad = AP;
                4, 5, 6:    ad = DP;
                7:          ad = 16'hFC3A;
                default:    ad = 16'($urandom);
            endcase
            kind = $urandom_range(0, 2);
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 7) == 0) ad = ($urandom_range(0, 1) == 0) ? AP : DP;
                io = ($urandom_range(0, 9) == 0);
                rr = ($urandom_range(0, 59) == 0);
                step(rr, ad, io, kind == 0, kind == 1, 8'($urandom));
            end
            gap = $urandom_range(0, 2);
            idle(gap);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
